alu_exec_unit: RTL and testbench

Parametrised execution unit for the datapath. It combines an adder/logic ALU, a barrel shifter, a sequential shift-add multiplier, a sequential restoring divider and HI/LO result registers behind one start/done handshake. It sits where the fixed 32-bit ALU/shifter/multiplier top sits and generalises it in three ways: configurable width, unsigned divide, and explicit busy/done status for multi-cycle operations.

---
 rtl/alu_exec_unit.sv | 173 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execution unit: single-cycle ALU/shifter plus sequential multiply and divide
// sharing one start/done handshake and a HI/LO result pair.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       ctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [5:0] OP_ADD   = 6'b100000;
  localparam logic [5:0] OP_SUB   = 6'b100010;
  localparam logic [5:0] OP_AND   = 6'b100100;
  localparam logic [5:0] OP_OR    = 6'b100101;
  localparam logic [5:0] OP_SLT   = 6'b101010;
  localparam logic [5:0] OP_SLL   = 6'b000000;
  localparam logic [5:0] OP_SRL   = 6'b000010;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0]   opb, opb_n;
  logic [WIDTH-1:0]   result_n, hi_n, lo_n;
  logic               done_n, dz_n;

  logic [WIDTH-1:0]   alu_out;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_r;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_step;

  assign busy = (state != S_IDLE);

  always_comb begin
    alu_out = '0;
    case (ctrl)
      OP_ADD:  alu_out = A + B;
      OP_SUB:  alu_out = A - B;
      OP_AND:  alu_out = A & B;
      OP_OR:   alu_out = A | B;
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL:  alu_out = A << B[SHW-1:0];
      OP_SRL:  alu_out = A >> B[SHW-1:0];
      OP_MFHI: alu_out = hi;
      OP_MFLO: alu_out = lo;
      default: alu_out = '0;
    endcase
  end

  // acc = {partial product, remaining multiplier}; each step adds then shifts right.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb & {WIDTH{acc[0]}}};
    mul_step = {mul_sum, acc[WIDTH-1:1]};
  end

  // acc = {partial remainder, dividend/quotient}; quotient bits shift in at the bottom.
  always_comb begin
    div_r    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge   = (div_r >= {1'b0, opb});
    div_rem  = div_ge ? (div_r[WIDTH-1:0] - opb) : div_r[WIDTH-1:0];
    div_step = {div_rem, acc[WIDTH-2:0], div_ge};
  end

  always_comb begin
    // NOTE: every next-value starts at a default so no path leaves it unassigned (no latches).
    state_n  = state;
    cnt_n    = cnt;
    acc_n    = acc;
    opb_n    = opb;
    result_n = result;
    hi_n     = hi;
    lo_n     = lo;
    done_n   = 1'b0;
    dz_n     = dz;
    case (state)
      S_IDLE: begin
        if (start) begin
          dz_n  = 1'b0;
          cnt_n = CW'(WIDTH);
          acc_n = {{WIDTH{1'b0}}, A};
          opb_n = B;
          case (ctrl)
            OP_MULTU: state_n = S_MUL;
            OP_DIVU: begin
              if (B == '0) begin
                hi_n     = A;
                lo_n     = '1;
                result_n = '1;
                dz_n     = 1'b1;
                done_n   = 1'b1;
              end else begin
                state_n = S_DIV;
              end
            end
            default: begin
              result_n = alu_out;
              done_n   = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        cnt_n = cnt - CW'(1);
        acc_n = mul_step;
        if (cnt == CW'(1)) begin
          state_n  = S_IDLE;
          hi_n     = mul_step[2*WIDTH-1:WIDTH];
          lo_n     = mul_step[WIDTH-1:0];
          result_n = mul_step[WIDTH-1:0];
          done_n   = 1'b1;
        end
      end
      S_DIV: begin
        cnt_n = cnt - CW'(1);
        acc_n = div_step;
        if (cnt == CW'(1)) begin
          state_n  = S_IDLE;
          hi_n     = div_step[2*WIDTH-1:WIDTH];
          lo_n     = div_step[WIDTH-1:0];
          result_n = div_step[WIDTH-1:0];
          done_n   = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      result <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      dz     <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      acc    <= acc_n;
      opb    <= opb_n;
      result <= result_n;
      hi     <= hi_n;
      lo     <= lo_n;
      done   <= done_n;
      dz     <= dz_n;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: fixed vectors, corner-case sequences and
// randomized operations against an arithmetic reference model (WIDTH 32 and 8).
module tb_alu_exec_unit;

  localparam logic [5:0] OP_ADD   = 6'b100000;
  localparam logic [5:0] OP_SUB   = 6'b100010;
  localparam logic [5:0] OP_AND   = 6'b100100;
  localparam logic [5:0] OP_OR    = 6'b100101;
  localparam logic [5:0] OP_SLT   = 6'b101010;
  localparam logic [5:0] OP_SLL   = 6'b000000;
  localparam logic [5:0] OP_SRL   = 6'b000010;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  logic clk, rst;

  logic        start32, busy32, done32, dz32;
  logic [5:0]  ctrl32;
  logic [31:0] a32, b32, result32, hi32, lo32;

  logic        start8, busy8, done8, dz8;
  logic [5:0]  ctrl8;
  logic [7:0]  a8, b8, result8, hi8, lo8;

  alu_exec_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .ctrl(ctrl32), .A(a32), .B(b32),
    .result(result32), .hi(hi32), .lo(lo32), .busy(busy32), .done(done32), .dz(dz32)
  );

  alu_exec_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .ctrl(ctrl8), .A(a8), .B(b8),
    .result(result8), .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .dz(dz8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference model: operation semantics with plain arithmetic on a w-bit machine.
  function automatic void model(input logic [5:0] c, input logic [63:0] a, input logic [63:0] b,
                                input int w, input logic [63:0] hi_in, input logic [63:0] lo_in,
                                output logic [63:0] r, output logic [63:0] hi_o,
                                output logic [63:0] lo_o, output logic z, output int lat);
    logic [63:0] mask;
    logic [63:0] prod;
    longint      sa, sb;
    mask = (64'd1 << w) - 64'd1;
    hi_o = hi_in;
    lo_o = lo_in;
    z    = 1'b0;
    lat  = 0;
    r    = '0;
    case (c)
      OP_ADD:  r = (a + b) & mask;
      OP_SUB:  r = (a - b) & mask;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLT: begin
        sa = longint'(a);
        sb = longint'(b);
        if (a[w-1]) sa = sa - (longint'(1) << w);
        if (b[w-1]) sb = sb - (longint'(1) << w);
        r = (sa < sb) ? 64'd1 : 64'd0;
      end
      OP_SLL:  r = (a << (b % 64'(w))) & mask;
      OP_SRL:  r = a >> (b % 64'(w));
      OP_MFHI: r = hi_in;
      OP_MFLO: r = lo_in;
      OP_MULTU: begin
        prod = a * b;
        hi_o = prod >> w;
        lo_o = prod & mask;
        r    = lo_o;
        lat  = w;
      end
      OP_DIVU: begin
        if (b == 0) begin
          hi_o = a;
          lo_o = mask;
          r    = mask;
          z    = 1'b1;
        end else begin
          lo_o = a / b;
          hi_o = a % b;
          r    = lo_o;
          lat  = w;
        end
      end
      default: r = '0;
    endcase
  endfunction

  // Issue one op; lat counts edges after the accepting edge until done is seen.
  task automatic issue32(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] r, output logic [63:0] h, output logic [63:0] l,
                         output logic z, output int lat, output logic bk, output logic bd);
    @(negedge clk);
    start32 = 1'b1; ctrl32 = c; a32 = a; b32 = b;
    @(posedge clk); #1;
    start32 = 1'b0; a32 = $urandom; b32 = $urandom;
    bk  = busy32;
    lat = 0;
    while (!done32 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    r = 64'(result32); h = 64'(hi32); l = 64'(lo32); z = dz32; bd = busy32;
  endtask

  task automatic issue8(input logic [5:0] c, input logic [7:0] a, input logic [7:0] b,
                        output logic [63:0] r, output logic [63:0] h, output logic [63:0] l,
                        output logic z, output int lat, output logic bk, output logic bd);
    @(negedge clk);
    start8 = 1'b1; ctrl8 = c; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    bk  = busy8;
    lat = 0;
    while (!done8 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    r = 64'(result8); h = 64'(hi8); l = 64'(lo8); z = dz8; bd = busy8;
  endtask

  task automatic verify(input string tag, input logic [63:0] r, input logic [63:0] h,
                        input logic [63:0] l, input logic z, input int lat, input logic bk,
                        input logic bd, input logic [63:0] er, input logic [63:0] eh,
                        input logic [63:0] el, input logic ez, input int elat);
    check({tag, "_result"}, r, er);
    check({tag, "_hi"}, h, eh);
    check({tag, "_lo"}, l, el);
    check({tag, "_dz"}, 64'(z), 64'(ez));
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_busy_after_accept"}, 64'(bk), 64'(elat > 0));
    check({tag, "_busy_with_done"}, 64'(bd), 64'd0);
  endtask

  typedef struct {
    logic [5:0]  ctrl;
    logic [31:0] a, b, res, hi, lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [63:0] r, h, l, er, eh, el, m_hi, m_lo;
    logic        z, ez, bk, bd;
    int          lat, elat, bad;
    logic [5:0]  ops[11];
    logic [5:0]  c;
    logic [31:0] ra, rb;

    vecs[0]  = '{OP_SUB,   32'd5,          32'd7,          32'hFFFF_FFFE, 32'd0,          32'd0,          1'b0, 0};
    vecs[1]  = '{OP_SLT,   32'hFFFF_FFFF,  32'd1,          32'd1,         32'd0,          32'd0,          1'b0, 0};
    vecs[2]  = '{OP_SLT,   32'd1,          32'hFFFF_FFFF,  32'd0,         32'd0,          32'd0,          1'b0, 0};
    vecs[3]  = '{OP_SLL,   32'd1,          32'h25,         32'h20,        32'd0,          32'd0,          1'b0, 0};
    vecs[4]  = '{OP_SRL,   32'h8000_0000,  32'd31,         32'd1,         32'd0,          32'd0,          1'b0, 0};
    vecs[5]  = '{OP_AND,   32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000, 32'd0,          32'd0,          1'b0, 0};
    vecs[6]  = '{OP_OR,    32'hF0F0_F0F0,  32'hFF00_FF00,  32'hFFF0_FFF0, 32'd0,          32'd0,          1'b0, 0};
    vecs[7]  = '{OP_ADD,   32'hFFFF_FFFF,  32'd2,          32'd1,         32'd0,          32'd0,          1'b0, 0};
    vecs[8]  = '{6'b111111, 32'd1,         32'd2,          32'd0,         32'd0,          32'd0,          1'b0, 0};
    vecs[9]  = '{OP_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFE,  32'd1,          1'b0, 32};
    vecs[10] = '{OP_MFHI,  32'd0,          32'd0,          32'hFFFF_FFFE, 32'hFFFF_FFFE,  32'd1,          1'b0, 0};
    vecs[11] = '{OP_DIVU,  32'd100,        32'd7,          32'd14,        32'd2,          32'd14,         1'b0, 32};
    vecs[12] = '{OP_MFHI,  32'd0,          32'd0,          32'd2,         32'd2,          32'd14,         1'b0, 0};
    vecs[13] = '{OP_DIVU,  32'd9,          32'd0,          32'hFFFF_FFFF, 32'd9,          32'hFFFF_FFFF,  1'b1, 0};
    vecs[14] = '{OP_ADD,   32'd1,          32'd1,          32'd2,         32'd9,          32'hFFFF_FFFF,  1'b0, 0};

    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLL, OP_SRL, OP_MFHI, OP_MFLO, OP_MULTU, OP_DIVU};

    rst = 1'b1;
    start32 = 1'b0; ctrl32 = '0; a32 = '0; b32 = '0;
    start8  = 1'b0; ctrl8  = '0; a8  = '0; b8  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", 64'(result32), 64'd0);
    check("reset_hilo", {hi32, lo32}, 64'd0);
    check("reset_flags", {61'd0, busy32, done32, dz32}, 64'd0);
    check("reset_w8_all", {29'd0, result8, hi8, lo8, busy8, done8, dz8}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      issue32(vecs[i].ctrl, vecs[i].a, vecs[i].b, r, h, l, z, lat, bk, bd);
      verify($sformatf("vec%0d", i), r, h, l, z, lat, bk, bd,
             64'(vecs[i].res), 64'(vecs[i].hi), 64'(vecs[i].lo), vecs[i].dz, vecs[i].lat);
    end

    // Asynchronous reset part-way through a multiply.
    @(negedge clk);
    start32 = 1'b1; ctrl32 = OP_MULTU; a32 = 32'd12345; b32 = 32'd678;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_result", 64'(result32), 64'd0);
    check("async_rst_hilo", {hi32, lo32}, 64'd0);
    check("async_rst_flags", {61'd0, busy32, done32, dz32}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue32(OP_ADD, 32'd3, 32'd4, r, h, l, z, lat, bk, bd);
    verify("post_rst_add", r, h, l, z, lat, bk, bd, 64'd7, 64'd0, 64'd0, 1'b0, 0);
    @(posedge clk); #1;
    check("done_single_pulse", 64'(done32), 64'd0);

    // Multiply with inputs changing and a stray start part-way through.
    bad = 0;
    @(negedge clk);
    start32 = 1'b1; ctrl32 = OP_MULTU; a32 = '1; b32 = '1;
    @(posedge clk); #1;
    start32 = 1'b0; a32 = '0; b32 = '0;
    check("mul_busy_at_k", 64'(busy32), 64'd1);
    for (int i = 1; i < 32; i++) begin
      if (i == 10) begin
        start32 = 1'b1; ctrl32 = OP_ADD; a32 = 32'd5; b32 = 32'd6;
      end
      @(posedge clk); #1;
      start32 = 1'b0;
      if (done32 || !busy32) bad++;
    end
    check("mul_busy_window", 64'(bad), 64'd0);
    @(posedge clk); #1;
    check("mul_done_at_k32", {62'd0, done32, busy32}, 64'd2);
    check("mul_hi", 64'(hi32), 64'hFFFF_FFFE);
    check("mul_lo", 64'(lo32), 64'd1);
    check("mul_result", 64'(result32), 64'd1);

    // Back-to-back: MFLO accepted in the multiply's done cycle.
    issue32(OP_MULTU, 32'd6, 32'd7, r, h, l, z, lat, bk, bd);
    verify("b2b_mul", r, h, l, z, lat, bk, bd, 64'd42, 64'd0, 64'd42, 1'b0, 32);
    issue32(OP_MFLO, 32'd0, 32'd0, r, h, l, z, lat, bk, bd);
    verify("b2b_mflo", r, h, l, z, lat, bk, bd, 64'd42, 64'd0, 64'd42, 1'b0, 0);
    issue32(OP_MFHI, 32'd0, 32'd0, r, h, l, z, lat, bk, bd);
    verify("b2b_mfhi", r, h, l, z, lat, bk, bd, 64'd0, 64'd0, 64'd42, 1'b0, 0);

    m_hi = 64'd0;
    m_lo = 64'd42;
    for (int i = 0; i < 40; i++) begin
      c  = ops[$urandom_range(10, 0)];
      ra = $urandom;
      rb = $urandom;
      if (c == OP_DIVU && $urandom_range(3, 0) == 0) rb = '0;
      if (c == OP_DIVU && $urandom_range(1, 0) == 0) rb = rb >> $urandom_range(28, 8);
      model(c, 64'(ra), 64'(rb), 32, m_hi, m_lo, er, eh, el, ez, elat);
      m_hi = eh;
      m_lo = el;
      issue32(c, ra, rb, r, h, l, z, lat, bk, bd);
      verify($sformatf("rnd32_%0d_op%b", i, c), r, h, l, z, lat, bk, bd, er, eh, el, ez, elat);
    end

    // Narrow instance.
    issue8(OP_MULTU, 8'hF0, 8'h11, r, h, l, z, lat, bk, bd);
    verify("w8_mul", r, h, l, z, lat, bk, bd, 64'hF0, 64'h0F, 64'hF0, 1'b0, 8);
    issue8(OP_SLL, 8'h01, 8'h0A, r, h, l, z, lat, bk, bd);
    verify("w8_sll", r, h, l, z, lat, bk, bd, 64'h04, 64'h0F, 64'hF0, 1'b0, 0);

    m_hi = 64'h0F;
    m_lo = 64'hF0;
    for (int i = 0; i < 20; i++) begin
      c  = ops[$urandom_range(10, 0)];
      ra = 32'($urandom_range(255, 0));
      rb = 32'($urandom_range(255, 0));
      if (c == OP_DIVU && $urandom_range(3, 0) == 0) rb = '0;
      model(c, 64'(ra), 64'(rb), 8, m_hi, m_lo, er, eh, el, ez, elat);
      m_hi = eh;
      m_lo = el;
      issue8(c, ra[7:0], rb[7:0], r, h, l, z, lat, bk, bd);
      verify($sformatf("rnd8_%0d_op%b", i, c), r, h, l, z, lat, bk, bd, er, eh, el, ez, elat);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
